exit_payment_controller: RTL and testbench
==========================================

// Module: exit_payment_controller
// PURPOSE
//  Downstream consumer of the parking-system fee path. Captures fee_amount on fee_valid,
//  collects coin payments against it, and computes change. Issues a one-cycle payment_ok
//  to the exit FSM, or a refund on cancel. Sits between the fee calculator and the exit barrier logic.
// PARAMETERS
//  FEE_W          8     width of fee_amount / coin_value / change_amount
//  TIMEOUT_CYCLES 1000  idle cycles in WAIT_PAY before auto-cancel (PAYMENT_TIMEOUT_EN only)
// PORTS
//  clk            in   1      system clock, rising edge
//  reset          in   1      asynchronous, active-high reset
//  fee_amount     in   FEE_W  fee to collect; sampled only when fee_valid=1
//  fee_valid      in   1      one-cycle strobe, fee_amount valid
//  coin_valid     in   1      one-cycle strobe, one coin inserted
//  coin_value     in   FEE_W  value of inserted coin, sampled with coin_valid
//  cancel         in   1      driver abort request (level; acted on while in WAIT_PAY)
//  busy           out  1      1 while a transaction is open (state != IDLE)
//  amount_due     out  FEE_W  fee minus paid so far, floored at 0; 0 in IDLE
//  paid_total     out  FEE_W+1 running coin sum, saturating at all-ones
//  payment_ok     out  1      one-cycle pulse: fee fully covered
//  change_valid   out  1      one-cycle pulse, coincident with payment_ok, when change_amount>0
//  change_amount  out  FEE_W  paid_total-fee, clamped to FEE_W all-ones; held until next transaction
//  refund_valid   out  1      one-cycle pulse: transaction aborted, refund_amount valid
//  refund_amount  out  FEE_W+1 coins returned on abort; held until next transaction
//  coin_reject    out  1      one-cycle pulse: coin_valid seen outside WAIT_PAY (coin not counted)
//  timeout_alarm  out  1      one-cycle pulse on auto-cancel (tied 0 without macro)
// BEHAVIOUR
//  Reset: state=IDLE; every output and internal register is 0.
//  All outputs registered; pulses assert the cycle after the triggering input edge.
//  FSM: IDLE -> WAIT_PAY -> SETTLE -> IDLE; WAIT_PAY -> ABORT -> IDLE.
//   IDLE: fee_valid captures fee, clears paid_total/change/refund, -> WAIT_PAY.
//         fee_amount==0: -> SETTLE directly, payment_ok next cycle, change 0.
//   WAIT_PAY: coin_valid: paid_total += coin_value (saturating add at FEE_W+1 bits).
//         If the new paid_total >= fee -> SETTLE. Else if cancel -> ABORT.
//         Coin and cancel in the same cycle: the coin is counted first; covering the fee wins over cancel.
//   SETTLE (1 cycle): payment_ok=1, change_amount latched, change_valid if >0, -> IDLE.
//   ABORT (1 cycle): refund_valid=1, refund_amount=paid_total (may be 0), -> IDLE.
//  fee_valid outside IDLE: ignored (no re-capture, no error).
//  coin_valid outside WAIT_PAY (including SETTLE/ABORT cycles): coin_reject pulse, sum unchanged.
//  amount_due = (fee > paid_total) ? fee - paid_total : 0, updated same cycle as paid_total.
//  Reset asserted mid-transaction: immediate return to IDLE; no payment_ok or refund pulse is issued.
// CONFIGURATION
//  PAYMENT_TIMEOUT_EN defined: counter clears on WAIT_PAY entry and on every coin_valid.
//   Reaching TIMEOUT_CYCLES in WAIT_PAY forces ABORT, and timeout_alarm pulses with refund_valid.
//  Not defined: no counter; WAIT_PAY waits indefinitely; timeout_alarm is constant 0.
// STRUCTURE
//  parking_pkg: pay_state_t enum {IDLE,WAIT_PAY,SETTLE,ABORT} (2-bit) and FEE_W default constant.
//  One sub-module: payment_timer (clear/enable/expired), instantiated only under PAYMENT_TIMEOUT_EN.
// TESTING
//  fee_valid fee=25; coins 10,10,5 -> payment_ok one cycle after 3rd coin, change_valid=0, amount_due 0.
//  fee=25; coins 20,20 -> payment_ok, change_valid=1, change_amount=15.
//  fee=30; coin 10 then cancel -> refund_valid, refund_amount=10, busy falls next cycle.
//  fee=10; coin 10 with cancel same cycle -> payment_ok, no refund_valid.
//  coin in IDLE -> coin_reject pulse, paid_total 0. fee=0 -> payment_ok with no coins.
//  [PAYMENT_TIMEOUT_EN, TIMEOUT_CYCLES=8] fee=5, coin 2, wait 8 cycles -> timeout_alarm+refund 2.
//  Reset mid-WAIT_PAY -> all outputs 0, no pulses.

Source files
------------

// File: rtl/parking_pkg.sv
// Parking exit payment: shared types and defaults.
// Holds the payment FSM state encoding and the default fee width.
package parking_pkg;

    localparam int FEE_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_PAY = 2'd1,
        SETTLE   = 2'd2,
        ABORT    = 2'd3
    } pay_state_t;

endpackage

// File: rtl/payment_timer.sv
// Payment idle timer: counts idle cycles, flags the final one.
// Ports: clk, reset (async, high), clear, enable, expired.
// expired is high during the CYCLES-th consecutive enabled cycle.
module payment_timer #(
    parameter int CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/exit_payment_controller.sv
// Exit payment controller: fee capture, coin collection, change/refund.
// Inputs: clk, reset (async, high), fee_amount/fee_valid,
//   coin_value/coin_valid, cancel.
// Outputs: busy, amount_due, paid_total, payment_ok, change_valid,
//   change_amount, refund_valid, refund_amount, coin_reject, timeout_alarm.
// Optional: PAYMENT_TIMEOUT_EN adds an idle auto-cancel in WAIT_PAY.
module exit_payment_controller
    import parking_pkg::*;
#(
    parameter int FEE_W          = FEE_W_DEF,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [FEE_W-1:0] fee_amount,
    input  logic             fee_valid,
    input  logic             coin_valid,
    input  logic [FEE_W-1:0] coin_value,
    input  logic             cancel,
    output logic             busy,
    output logic [FEE_W-1:0] amount_due,
    output logic [FEE_W:0]   paid_total,
    output logic             payment_ok,
    output logic             change_valid,
    output logic [FEE_W-1:0] change_amount,
    output logic             refund_valid,
    output logic [FEE_W:0]   refund_amount,
    output logic             coin_reject,
    output logic             timeout_alarm
);

    pay_state_t       state_q, state_d;
    logic [FEE_W-1:0] fee_q, fee_d;
    logic [FEE_W:0]   paid_q, paid_d;
    logic [FEE_W-1:0] due_q, due_d;
    logic [FEE_W-1:0] change_q, change_d;
    logic [FEE_W:0]   refund_q, refund_d;
    logic             pay_ok_q, pay_ok_d;
    logic             chg_v_q, chg_v_d;
    logic             ref_v_q, ref_v_d;
    logic             rej_q, rej_d;
    logic             alarm_q, alarm_d;

    logic [FEE_W+1:0] sum;
    logic [FEE_W:0]   paid_add;
    logic [FEE_W:0]   diff;
    logic             expired;

`ifdef PAYMENT_TIMEOUT_EN
    payment_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != WAIT_PAY || coin_valid),
        .enable  (state_q == WAIT_PAY),
        .expired (expired)
    );
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES != 0);
    assign expired    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        fee_d    = fee_q;
        paid_d   = paid_q;
        change_d = change_q;
        refund_d = refund_q;
        pay_ok_d = 1'b0;
        chg_v_d  = 1'b0;
        ref_v_d  = 1'b0;
        rej_d    = 1'b0;
        alarm_d  = 1'b0;
        diff     = '0;
        // One extra bit catches overflow of the FEE_W+1 running sum.
        sum      = {1'b0, paid_q} + (FEE_W+2)'(coin_value);
        paid_add = sum[FEE_W+1] ? '1 : sum[FEE_W:0];
        unique case (state_q)
            IDLE: begin
                rej_d = coin_valid;
                if (fee_valid) begin
                    fee_d    = fee_amount;
                    paid_d   = '0;
                    change_d = '0;
                    refund_d = '0;
                    if (fee_amount == '0) begin
                        state_d  = SETTLE;
                        pay_ok_d = 1'b1;
                    end else begin
                        state_d = WAIT_PAY;
                    end
                end
            end
            WAIT_PAY: begin
                if (coin_valid) begin
                    paid_d = paid_add;
                end
                // Covering the fee wins over cancel and timeout.
                if (paid_d >= {1'b0, fee_q}) begin
                    state_d  = SETTLE;
                    pay_ok_d = 1'b1;
                    diff     = paid_d - {1'b0, fee_q};
                    change_d = diff[FEE_W] ? '1 : diff[FEE_W-1:0];
                    chg_v_d  = (change_d != '0);
                end else if (cancel || expired) begin
                    state_d  = ABORT;
                    ref_v_d  = 1'b1;
                    refund_d = paid_d;
                    alarm_d  = expired;
                end
            end
            SETTLE, ABORT: begin
                rej_d   = coin_valid;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        due_d = '0;
        if (state_d != IDLE && {1'b0, fee_d} > paid_d) begin
            due_d = fee_d - paid_d[FEE_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            fee_q    <= '0;
            paid_q   <= '0;
            due_q    <= '0;
            change_q <= '0;
            refund_q <= '0;
            pay_ok_q <= 1'b0;
            chg_v_q  <= 1'b0;
            ref_v_q  <= 1'b0;
            rej_q    <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            fee_q    <= fee_d;
            paid_q   <= paid_d;
            due_q    <= due_d;
            change_q <= change_d;
            refund_q <= refund_d;
            pay_ok_q <= pay_ok_d;
            chg_v_q  <= chg_v_d;
            ref_v_q  <= ref_v_d;
            rej_q    <= rej_d;
            alarm_q  <= alarm_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign amount_due    = due_q;
    assign paid_total    = paid_q;
    assign payment_ok    = pay_ok_q;
    assign change_valid  = chg_v_q;
    assign change_amount = change_q;
    assign refund_valid  = ref_v_q;
    assign refund_amount = refund_q;
    assign coin_reject   = rej_q;
    assign timeout_alarm = alarm_q;

endmodule

// File: tb/tb_exit_payment_controller.sv
// Directed bench for exit_payment_controller.
// Inputs change and outputs are checked 1ns after each rising edge.
module tb_exit_payment_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] fee_amount;
    logic       fee_valid;
    logic       coin_valid;
    logic [7:0] coin_value;
    logic       cancel;
    logic       busy;
    logic [7:0] amount_due;
    logic [8:0] paid_total;
    logic       payment_ok;
    logic       change_valid;
    logic [7:0] change_amount;
    logic       refund_valid;
    logic [8:0] refund_amount;
    logic       coin_reject;
    logic       timeout_alarm;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exit_payment_controller #(
        .FEE_W          (8),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fee_amount    (fee_amount),
        .fee_valid     (fee_valid),
        .coin_valid    (coin_valid),
        .coin_value    (coin_value),
        .cancel        (cancel),
        .busy          (busy),
        .amount_due    (amount_due),
        .paid_total    (paid_total),
        .payment_ok    (payment_ok),
        .change_valid  (change_valid),
        .change_amount (change_amount),
        .refund_valid  (refund_valid),
        .refund_amount (refund_amount),
        .coin_reject   (coin_reject),
        .timeout_alarm (timeout_alarm)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic give_fee(input logic [7:0] f);
        fee_valid  = 1'b1;
        fee_amount = f;
        step();
        fee_valid  = 1'b0;
        fee_amount = '0;
    endtask

    task automatic give_coin(input logic [7:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        step();
        coin_valid = 1'b0;
        coin_value = '0;
    endtask

    initial begin
        reset      = 1'b1;
        fee_amount = '0;
        fee_valid  = 1'b0;
        coin_valid = 1'b0;
        coin_value = '0;
        cancel     = 1'b0;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_due", amount_due, 0);
        check("rst_paid", paid_total, 0);
        check("rst_ok", payment_ok, 0);
        check("rst_chg", change_amount, 0);
        check("rst_ref", refund_amount, 0);
        check("rst_rej", coin_reject, 0);
        reset = 1'b0;
        step();

        // Coin while idle is rejected and not counted.
        give_coin(8'd7);
        check("idle_rej", coin_reject, 1);
        check("idle_paid", paid_total, 0);
        check("idle_busy", busy, 0);
        step();
        check("idle_rej_end", coin_reject, 0);

        // Exact payment 10+10+5 against 25.
        give_fee(8'd25);
        check("t1_busy", busy, 1);
        check("t1_due0", amount_due, 25);
        give_coin(8'd10);
        check("t1_paid1", paid_total, 10);
        check("t1_due1", amount_due, 15);
        give_coin(8'd10);
        check("t1_due2", amount_due, 5);
        check("t1_ok_early", payment_ok, 0);
        give_coin(8'd5);
        check("t1_ok", payment_ok, 1);
        check("t1_chgv", change_valid, 0);
        check("t1_due3", amount_due, 0);
        check("t1_paid3", paid_total, 25);
        step();
        check("t1_ok_end", payment_ok, 0);
        check("t1_idle", busy, 0);

        // Overpayment 20+20 against 25 gives change 15.
        give_fee(8'd25);
        give_coin(8'd20);
        check("t2_due", amount_due, 5);
        give_coin(8'd20);
        check("t2_ok", payment_ok, 1);
        check("t2_chgv", change_valid, 1);
        check("t2_chg", change_amount, 15);
        check("t2_paid", paid_total, 40);
        step();
        check("t2_chgv_end", change_valid, 0);
        check("t2_chg_hold", change_amount, 15);

        // Cancel after a partial payment refunds it.
        give_fee(8'd30);
        check("t3_chg_clr", change_amount, 0);
        give_fee(8'd50);
        check("t3_fee_ignored", amount_due, 30);
        give_coin(8'd10);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("t3_refv", refund_valid, 1);
        check("t3_ref", refund_amount, 10);
        check("t3_ok", payment_ok, 0);
        check("t3_busy", busy, 1);
        check("t3_alarm", timeout_alarm, 0);
        step();
        check("t3_busy_end", busy, 0);
        check("t3_refv_end", refund_valid, 0);
        check("t3_ref_hold", refund_amount, 10);

        // Covering coin wins over simultaneous cancel.
        give_fee(8'd10);
        coin_valid = 1'b1;
        coin_value = 8'd10;
        cancel     = 1'b1;
        step();
        coin_valid = 1'b0;
        cancel     = 1'b0;
        check("t4_ok", payment_ok, 1);
        check("t4_refv", refund_valid, 0);
        check("t4_ref", refund_amount, 0);
        // Coin during SETTLE is rejected.
        give_coin(8'd3);
        check("t4_settle_rej", coin_reject, 1);
        check("t4_settle_paid", paid_total, 10);
        check("t4_idle", busy, 0);

        // Zero fee settles immediately.
        give_fee(8'd0);
        check("t5_ok", payment_ok, 1);
        check("t5_chgv", change_valid, 0);
        check("t5_busy", busy, 1);
        step();
        check("t5_idle", busy, 0);

        // Largest fee, large change.
        give_fee(8'd255);
        give_coin(8'd254);
        check("t6_due", amount_due, 1);
        give_coin(8'd255);
        check("t6_paid", paid_total, 509);
        check("t6_chg", change_amount, 254);
        check("t6_chgv", change_valid, 1);
        step();

`ifdef PAYMENT_TIMEOUT_EN
        give_fee(8'd5);
        give_coin(8'd2);
        for (int i = 0; i < 7; i++) begin
            step();
        end
        check("to_early", refund_valid, 0);
        step();
        check("to_alarm", timeout_alarm, 1);
        check("to_refv", refund_valid, 1);
        check("to_ref", refund_amount, 2);
        step();
        check("to_alarm_end", timeout_alarm, 0);
        check("to_idle", busy, 0);
`else
        give_fee(8'd5);
        give_coin(8'd2);
        for (int i = 0; i < 20; i++) begin
            step();
        end
        check("nto_busy", busy, 1);
        check("nto_refv", refund_valid, 0);
        check("nto_alarm", timeout_alarm, 0);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("nto_ref", refund_amount, 2);
        step();
`endif

        // Reset mid-transaction clears everything at once.
        give_fee(8'd40);
        give_coin(8'd10);
        check("r_paid_pre", paid_total, 10);
        reset = 1'b1;
        #2;
        check("r_busy", busy, 0);
        check("r_paid", paid_total, 0);
        check("r_due", amount_due, 0);
        step();
        reset = 1'b0;
        step();
        check("r_ok", payment_ok, 0);
        check("r_refv", refund_valid, 0);
        check("r_ref", refund_amount, 0);
        check("r_busy_after", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
